// File: rtl/tvs_pkg.sv
// Shared types and field helpers for the test-vector sequencer.
// Optional build macro: TVS_STOP_ON_ERROR_EN.
package tvs_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 7;
  localparam int TV_W      = IN_W_DEF + OUT_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } tvs_state_t;

  function automatic logic [IN_W_DEF-1:0] tv_inputs(
    input logic [TV_W-1:0] w
  );
    return w[TV_W-1:OUT_W_DEF];
  endfunction

  function automatic logic [OUT_W_DEF-1:0] tv_expected(
    input logic [TV_W-1:0] w
  );
    return w[OUT_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/tvs_settle_timer.sv
// Loadable down-counter with zero flag; paces the DUT settle window.
// Used by testvector_sequencer (optional macro: TVS_STOP_ON_ERROR_EN).
module tvs_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/testvector_sequencer.sv
// On-chip self-test controller: walks a vector ROM, drives and checks a DUT.
// Optional macro TVS_STOP_ON_ERROR_EN: halt on first mismatch, report it.
module testvector_sequencer
  import tvs_pkg::*;
#(
  parameter int IN_W          = IN_W_DEF,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int ADDR_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_vectors,
  output logic [ADDR_W-1:0]     vec_addr,
  input  logic [IN_W+OUT_W-1:0] vec_data,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      error_count,
  output logic [ADDR_W:0]       vector_count
`ifdef TVS_STOP_ON_ERROR_EN
  ,
  output logic [ADDR_W-1:0]     fail_index,
  output logic [OUT_W-1:0]      fail_value
`endif
);

  localparam int TW = IN_W + OUT_W;
  localparam logic [ADDR_W:0] MAXN =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0] SETTLE_LD =
    8'(SETTLE_CYCLES - 1);

  tvs_state_t state, nstate;

  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   clamped;
  logic [ADDR_W-1:0] index;
  logic [OUT_W-1:0]  expected;
  logic              start_ok;
  logic              mismatch;
  logic              last;
  logic              stop_hit;
  logic              tmr_zero;

  assign start_ok = start &&
    (state == IDLE || state == DONE);
  assign clamped  = (num_vectors > MAXN) ?
    MAXN : num_vectors;
  assign mismatch = (dut_out != expected);
  assign last     = ({1'b0, index} == count - 1'b1);

`ifdef TVS_STOP_ON_ERROR_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  assign vec_addr = index;
  assign done     = (state == DONE);
  assign busy     = (state == FETCH) ||
                    (state == APPLY) ||
                    (state == SETTLE) ||
                    (state == CHECK);
  assign pass     = done && (error_count == '0);

  tvs_settle_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == APPLY),
    .load_val (SETTLE_LD),
    .dec      (state == SETTLE),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nstate = (clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH:  nstate = APPLY;
      APPLY:  nstate = SETTLE;
      SETTLE: begin
        if (tmr_zero) nstate = CHECK;
      end
      CHECK: begin
        nstate = (last || stop_hit) ? DONE : FETCH;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count        <= '0;
      index        <= '0;
      expected     <= '0;
      dut_in       <= '0;
      error_count  <= '0;
      vector_count <= '0;
`ifdef TVS_STOP_ON_ERROR_EN
      fail_index   <= '0;
      fail_value   <= '0;
`endif
    end else begin
      if (start_ok) begin
        count        <= clamped;
        index        <= '0;
        error_count  <= '0;
        vector_count <= '0;
`ifdef TVS_STOP_ON_ERROR_EN
        fail_index   <= '0;
        fail_value   <= '0;
`endif
      end
      if (state == APPLY) begin
        dut_in   <= vec_data[TW-1:OUT_W];
        expected <= vec_data[OUT_W-1:0];
      end
      if (state == CHECK) begin
        if (mismatch && error_count != '1) begin
          error_count <= error_count + 1'b1;
        end
        vector_count <= vector_count + 1'b1;
        if (nstate == FETCH) begin
          index <= index + 1'b1;
        end
`ifdef TVS_STOP_ON_ERROR_EN
        if (mismatch) begin
          fail_index <= index;
          fail_value <= dut_out;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_testvector_sequencer.sv
// Scoreboard bench for testvector_sequencer driving a BCD-to-7seg model.
// Honours TVS_STOP_ON_ERROR_EN when the build defines it.
module tb_testvector_sequencer;

  typedef struct {
    int t0;
    int lat;
    int err;
    int vcnt;
    int pass;
    int fidx;
    int fval;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  num_vectors;
  logic [7:0]  vec_addr;
  logic [10:0] vec_data;
  logic [3:0]  dut_in;
  logic [6:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [8:0]  vector_count;
`ifdef TVS_STOP_ON_ERROR_EN
  logic [7:0]  fail_index;
  logic [6:0]  fail_value;
`endif

  logic [10:0] rom [256];
  exp_t        sb[$];
  exp_t        me;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        done_q = 1'b0;

  testvector_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_vectors  (num_vectors),
    .vec_addr     (vec_addr),
    .vec_data     (vec_data),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .error_count  (error_count),
    .vector_count (vector_count)
`ifdef TVS_STOP_ON_ERROR_EN
    ,
    .fail_index   (fail_index),
    .fail_value   (fail_value)
`endif
  );

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) vec_data <= rom[vec_addr];
  always_comb dut_out = seg7(int'(dut_in));

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic fill(input int c0, input int c1);
    for (int i = 0; i < 256; i++) begin
      rom[i] = {4'(i % 10), seg7(i % 10)};
      if (i == c0 || i == c1) rom[i][0] = ~rom[i][0];
    end
  endtask

  task automatic issue(input int n, input int lat,
                       input int err, input int vcnt,
                       input int p, input int fidx,
                       input int fval);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    num_vectors = 9'(n);
    e.t0 = cyc; e.lat = lat; e.err = err;
    e.vcnt = vcnt; e.pass = p;
    e.fidx = fidx; e.fval = fval;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && sb.size() != 0; i++)
      @(negedge clk);
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset && done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("latency", 32'(cyc - me.t0), 32'(me.lat));
        chk("error_count", 32'(error_count), 32'(me.err));
        chk("vector_count", 32'(vector_count), 32'(me.vcnt));
        chk("pass", 32'(pass), 32'(me.pass));
        chk("busy_at_done", 32'(busy), 0);
`ifdef TVS_STOP_ON_ERROR_EN
        chk("fail_index", 32'(fail_index), 32'(me.fidx));
        chk("fail_value", 32'(fail_value), 32'(me.fval));
`endif
      end
    end
    done_q = done;
  end

  initial begin
    logic bad;
    reset = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    fill(-1, -1);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(error_count), 0);
    chk("rst_vcnt", 32'(vector_count), 0);
    chk("rst_addr", 32'(vec_addr), 0);
    chk("rst_dut_in", 32'(dut_in), 0);
    reset = 1'b1;
    @(negedge clk);

    // zero-length run from IDLE
    issue(0, 1, 0, 0, 1, 0, 0);
    bad = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || vec_addr !== 8'd0) bad = 1'b1;
      @(negedge clk);
    end
    chk("n0_idle_bus", 32'(bad), 0);
    drain("n0");

    // vectors 3 and 7 corrupted; stray start mid-run
    fill(3, 7);
`ifdef TVS_STOP_ON_ERROR_EN
    issue(10, 21, 1, 4, 0, 3, 32'h4F);
`else
    issue(10, 51, 2, 10, 0, 0, 0);
`endif
    repeat (11) @(negedge clk);
    start = 1'b1;
    num_vectors = 9'd2;
    @(negedge clk);
    start = 1'b0;
    drain("corrupt37");

    // restart from DONE clears status on the start edge
    fill(-1, -1);
    issue(10, 51, 0, 10, 1, 0, 0);
    chk("restart_done", 32'(done), 0);
    chk("restart_err", 32'(error_count), 0);
    chk("restart_vcnt", 32'(vector_count), 0);
    chk("restart_busy", 32'(busy), 1);
    drain("clean");

    // abort during SETTLE of vector 4
    @(negedge clk);
    start = 1'b1;
    num_vectors = 9'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("abort_vcnt", 32'(vector_count), 4);
    chk("abort_dut_in", 32'(dut_in), 4);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_vcnt0", 32'(vector_count), 0);
    chk("abort_dut_in0", 32'(dut_in), 0);
    chk("abort_addr", 32'(vec_addr), 0);
    issue(10, 51, 0, 10, 1, 0, 0);
    drain("after_abort");

    // single corruption at vector 5
    fill(5, -1);
`ifdef TVS_STOP_ON_ERROR_EN
    issue(10, 31, 1, 6, 0, 5, 32'h6D);
`else
    issue(10, 51, 1, 10, 0, 0, 0);
`endif
    drain("corrupt5");

    // oversize count clamps to the full ROM
    fill(-1, -1);
    issue(300, 1281, 0, 256, 1, 0, 0);
    drain("clamp");
    chk("clamp_addr", 32'(vec_addr), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
